// File: rtl/pagerank_pkg.sv
// Shared types and index-width helpers for the pagerank graph loader and the DMP_serial engine.
package pagerank_pkg;

  typedef logic [31:0] node_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } loader_state_e;

  // Index width for an array dimension; a single-entry dimension still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pagerank_edge_decoder.sv
// Splits a node id into partition/slot and flags ids outside the graph (unsigned compare).
module pagerank_edge_decoder
  import pagerank_pkg::*;
#(
  parameter int NODES_IN_PARTITION = 4,
  parameter int NODES_IN_GRAPH     = 4,
  parameter int PW                 = 1,
  parameter int SW                 = 2
) (
  input  node_id_t        id,
  output logic [PW-1:0]   part,
  output logic [SW-1:0]   slot,
  output logic            in_range
);

  // Out-of-range ids map to slot 0 so they never index outside the arrays.
  always_comb begin
    in_range = (id < node_id_t'(NODES_IN_GRAPH));
    if (in_range) begin
      part = PW'(id / node_id_t'(NODES_IN_PARTITION));
      slot = SW'(id % node_id_t'(NODES_IN_PARTITION));
    end else begin
      part = {PW{1'b0}};
      slot = {SW{1'b0}};
    end
  end

endmodule

// File: rtl/pagerank_graph_loader.sv
// Builds partitioned source_id/out_degree/dest_id arrays from a serial edge stream, then hands off to the engine.
// Optional macro PR_LOADER_DEDUP_EN: collapse duplicate edges of a source instead of storing them.
module pagerank_graph_loader
  import pagerank_pkg::*;
#(
  parameter int NUM_PARTITIONS     = 1,
  parameter int NODES_IN_PARTITION = 4,
  parameter int NODES_IN_GRAPH     = 4,
  parameter int MAX_OUT_DEGREE     = 3
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     start,
  input  logic     edge_valid,
  output logic     edge_ready,
  input  node_id_t edge_src,
  input  node_id_t edge_dst,
  input  logic     edge_last,
  output node_id_t source_id  [NUM_PARTITIONS][NODES_IN_PARTITION],
  output node_id_t out_degree [NUM_PARTITIONS][NODES_IN_PARTITION],
  output node_id_t dest_id    [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_OUT_DEGREE],
  output logic     pagerank_enable,
  input  logic     pagerank_complete,
  output logic     busy,
  output logic     overflow_err,
  output logic     range_err
);

  localparam int PW = idx_w(NUM_PARTITIONS);
  localparam int SW = idx_w(NODES_IN_PARTITION);
  localparam int KW = idx_w(MAX_OUT_DEGREE);

  loader_state_e   state_r;
  logic [PW-1:0]   src_part_s;
  logic [SW-1:0]   src_slot_s;
  logic            src_in_range_s;
  logic [PW-1:0]   dst_part_s;
  logic [SW-1:0]   dst_slot_s;
  logic            dst_in_range_s;
  node_id_t        k_s;
  logic [KW-1:0]   k_idx_s;
  logic            full_s;
  logic            dup_s;
  logic            accept_s;

  pagerank_edge_decoder #(
    .NODES_IN_PARTITION(NODES_IN_PARTITION),
    .NODES_IN_GRAPH    (NODES_IN_GRAPH),
    .PW                (PW),
    .SW                (SW)
  ) u_src_dec (
    .id      (edge_src),
    .part    (src_part_s),
    .slot    (src_slot_s),
    .in_range(src_in_range_s)
  );

  pagerank_edge_decoder #(
    .NODES_IN_PARTITION(NODES_IN_PARTITION),
    .NODES_IN_GRAPH    (NODES_IN_GRAPH),
    .PW                (PW),
    .SW                (SW)
  ) u_dst_dec (
    .id      (edge_dst),
    .part    (dst_part_s),
    .slot    (dst_slot_s),
    .in_range(dst_in_range_s)
  );

  // Slot selection from the registered degree; a prior write has always landed by the next beat.
  always_comb begin
    accept_s = edge_valid & edge_ready;
    k_s      = out_degree[src_part_s][src_slot_s];
    k_idx_s  = KW'(k_s);
    full_s   = (k_s == node_id_t'(MAX_OUT_DEGREE));
    dup_s    = 1'b0;
`ifdef PR_LOADER_DEDUP_EN
    for (int j = 0; j < MAX_OUT_DEGREE; j++) begin
      if ((node_id_t'(j) < k_s) && (dest_id[src_part_s][src_slot_s][j] == edge_dst)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
`else
    dup_s = 1'b0;
`endif
  end

  // Loader FSM with registered handshake, status and graph arrays.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      edge_ready      <= 1'b0;
      pagerank_enable <= 1'b0;
      busy            <= 1'b0;
      overflow_err    <= 1'b0;
      range_err       <= 1'b0;
      for (int p = 0; p < NUM_PARTITIONS; p++) begin
        for (int s = 0; s < NODES_IN_PARTITION; s++) begin
          source_id[p][s]  <= 32'd0;
          out_degree[p][s] <= 32'd0;
          for (int k = 0; k < MAX_OUT_DEGREE; k++) dest_id[p][s][k] <= 32'd0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= CLEAR;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          for (int p = 0; p < NUM_PARTITIONS; p++) begin
            for (int s = 0; s < NODES_IN_PARTITION; s++) begin
              source_id[p][s]  <= node_id_t'(p * NODES_IN_PARTITION + s);
              out_degree[p][s] <= 32'd0;
              for (int k = 0; k < MAX_OUT_DEGREE; k++) dest_id[p][s][k] <= 32'd0;
            end
          end
          overflow_err <= 1'b0;
          range_err    <= 1'b0;
          edge_ready   <= 1'b1;
          state_r      <= LOAD;
        end
        LOAD: begin
          if (accept_s) begin
            if (!src_in_range_s || !dst_in_range_s) begin
              range_err <= 1'b1;
            end else if (!dup_s) begin
              if (full_s) begin
                overflow_err <= 1'b1;
              end else begin
                dest_id[src_part_s][src_slot_s][k_idx_s] <= edge_dst;
                out_degree[src_part_s][src_slot_s]       <= k_s + 32'd1;
              end
            end
            if (edge_last) begin
              edge_ready      <= 1'b0;
              pagerank_enable <= 1'b1;
              state_r         <= RUN;
            end
          end
        end
        RUN: begin
          if (pagerank_complete) begin
            pagerank_enable <= 1'b0;
            busy            <= 1'b0;
            state_r         <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_graph_loader.sv
// Self-checking bench for pagerank_graph_loader: directed and random edge lists against a graph model.
`timescale 1ns/100ps
module tb_pagerank_graph_loader;
  import pagerank_pkg::*;

  localparam int NP  = 1;
  localparam int NIP = 4;
  localparam int NG  = 4;
  localparam int MD  = 3;

  logic     clock = 1'b0;
  logic     reset_n = 1'b0;
  logic     start = 1'b0;
  logic     edge_valid = 1'b0;
  logic     edge_last = 1'b0;
  logic     pagerank_complete = 1'b0;
  node_id_t edge_src = 32'd0;
  node_id_t edge_dst = 32'd0;
  logic     edge_ready, pagerank_enable, busy, overflow_err, range_err;
  node_id_t source_id  [NP][NIP];
  node_id_t out_degree [NP][NIP];
  node_id_t dest_id    [NP][NIP][MD];

  pagerank_graph_loader #(
    .NUM_PARTITIONS(NP), .NODES_IN_PARTITION(NIP), .NODES_IN_GRAPH(NG), .MAX_OUT_DEGREE(MD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
    .source_id(source_id), .out_degree(out_degree), .dest_id(dest_id),
    .pagerank_enable(pagerank_enable), .pagerank_complete(pagerank_complete), .busy(busy),
    .overflow_err(overflow_err), .range_err(range_err)
  );

  always #5 clock = ~clock;

  typedef struct { int unsigned src; int unsigned dst; } edge_t;
  edge_t       edges[$];
  int unsigned m_deg [NG];
  int unsigned m_dst [NG][MD];
  bit          m_ov, m_rg;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Graph model: each source keeps an ordered list of destinations, capped at MD.
  task automatic model_load();
    bit dup;
    m_ov = 1'b0; m_rg = 1'b0;
    for (int n = 0; n < NG; n++) begin
      m_deg[n] = 0;
      for (int k = 0; k < MD; k++) m_dst[n][k] = 0;
    end
    foreach (edges[i]) begin
      if (edges[i].src >= NG || edges[i].dst >= NG) begin
        m_rg = 1'b1;
      end else begin
        dup = 1'b0;
`ifdef PR_LOADER_DEDUP_EN
        for (int k = 0; k < m_deg[edges[i].src]; k++)
          if (m_dst[edges[i].src][k] == edges[i].dst) dup = 1'b1;
`endif
        if (!dup) begin
          if (m_deg[edges[i].src] == MD) m_ov = 1'b1;
          else begin
            m_dst[edges[i].src][m_deg[edges[i].src]] = edges[i].dst;
            m_deg[edges[i].src]++;
          end
        end
      end
    end
  endtask

  task automatic check_graph(input string tag);
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NIP; s++) begin
        check({tag, "_srcid"}, source_id[p][s], p * NIP + s);
        check({tag, "_deg"}, out_degree[p][s], m_deg[p * NIP + s]);
        for (int k = 0; k < MD; k++) check({tag, "_dst"}, dest_id[p][s][k], m_dst[p * NIP + s][k]);
      end
    check({tag, "_ovf"}, overflow_err, m_ov);
    check({tag, "_rng"}, range_err, m_rg);
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NIP; s++) begin
        check({tag, "_srcid"}, source_id[p][s], 32'd0);
        check({tag, "_deg"}, out_degree[p][s], 32'd0);
        for (int k = 0; k < MD; k++) check({tag, "_dst"}, dest_id[p][s][k], 32'd0);
      end
    check({tag, "_ready"}, edge_ready, 1'b0);
    check({tag, "_en"}, pagerank_enable, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovf"}, overflow_err, 1'b0);
    check({tag, "_rng"}, range_err, 1'b0);
  endtask

  task automatic start_load(input string tag);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  // Send the first n edges; with toggle, valid and the ignored control inputs are randomised.
  task automatic send_edges(input string tag, input bit toggle, input int n);
    int i = 0;
    int budget = 0;
    while (i < n && budget < 2000) begin
      @(negedge clock);
      budget++;
      edge_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle) begin
        pagerank_complete = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      if (edge_valid) begin
        edge_src  = edges[i].src;
        edge_dst  = edges[i].dst;
        edge_last = (i == edges.size() - 1);
        if (edge_last) check({tag, "_en_pre"}, pagerank_enable, 1'b0);
      end else begin
        edge_src  = $urandom;
        edge_dst  = $urandom;
        edge_last = 1'($urandom_range(0, 1));
      end
      if (edge_valid && edge_ready) i++;
    end
    if (i < n) check({tag, "_timeout"}, i, n);
    @(negedge clock);
    edge_valid = 1'b0; edge_last = 1'b0; start = 1'b0; pagerank_complete = 1'b0;
    if (n == edges.size()) begin
      check({tag, "_en"}, pagerank_enable, 1'b1);
      check({tag, "_ready"}, edge_ready, 1'b0);
    end
  endtask

  // Hold RUN with stray edge beats, then pulse completion and confirm the graph stayed frozen.
  task automatic finish_run(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      edge_valid = 1'b1; edge_src = $urandom_range(0, NG - 1); edge_dst = $urandom_range(0, NG - 1);
    end
    edge_valid = 1'b0;
    check({tag, "_en_hold"}, pagerank_enable, 1'b1);
    pagerank_complete = 1'b1;
    @(negedge clock);
    pagerank_complete = 1'b0;
    check({tag, "_en_off"}, pagerank_enable, 1'b0);
    check({tag, "_busy_off"}, busy, 1'b0);
    check_graph({tag, "_after"});
  endtask

  task automatic set_edges(input int unsigned list[$]);
    edges.delete();
    for (int i = 0; i + 1 < list.size(); i += 2) edges.push_back('{list[i], list[i + 1]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // Reference graph
    set_edges('{0,1, 0,2, 1,3, 2,0, 2,1, 2,3, 3,2});
    model_load();
    start_load("t1");
    send_edges("t1", 1'b0, edges.size());
    check_graph("t1");
    finish_run("t1", 2);

    // Overflow on a fourth edge from node 0
    set_edges('{0,1, 0,2, 0,3, 0,1});
    model_load();
    start_load("t2");
    send_edges("t2", 1'b0, edges.size());
    check_graph("t2");
    finish_run("t2", 1);

    // Range drops, load still ends on the dropped last beat
    set_edges('{5,1, 1,9});
    model_load();
    start_load("t3");
    send_edges("t3", 1'b0, edges.size());
    check_graph("t3");
    finish_run("t3", 1);

    // Empty graph: single out-of-range last beat with a huge unsigned id
    set_edges('{32'hFFFF_FFFF, 0});
    model_load();
    start_load("t3b");
    send_edges("t3b", 1'b0, edges.size());
    check_graph("t3b");
    finish_run("t3b", 1);

    // Handshake with random valid gaps, completion after 10 RUN cycles
    set_edges('{0,1, 0,2, 1,3, 2,0, 2,1, 2,3, 3,2});
    model_load();
    start_load("t4");
    send_edges("t4", 1'b1, edges.size());
    check_graph("t4");
    finish_run("t4", 10);

    // Asynchronous reset mid-load, then a clean reload
    start_load("t5");
    send_edges("t5", 1'b0, 3);
    #2 reset_n = 1'b0;
    #0.5 check_zero("t5_async");
    #0.5 reset_n = 1'b1;
    @(negedge clock);
    check_zero("t5_idle");
    start_load("t5r");
    send_edges("t5r", 1'b0, edges.size());
    check_graph("t5r");
    finish_run("t5r", 1);

    // Duplicate edges: collapsed with the dedup macro, stored otherwise
    set_edges('{2,0, 2,0, 2,1});
    model_load();
    start_load("t6");
    send_edges("t6", 1'b0, edges.size());
    check_graph("t6");
    finish_run("t6", 1);

    // Random graphs with occasional out-of-range ids
    for (int r = 0; r < 6; r++) begin
      edges.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        edges.push_back('{$urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 4),
                          $urandom_range(0, 4)});
      model_load();
      start_load("rnd");
      send_edges("rnd", 1'b1, edges.size());
      check_graph("rnd");
      finish_run("rnd", $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
